// File: rtl/mips_pkg.sv
// Shared constants and payload types for the MIPS front end.
package mips_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000;

  // One decoded-stage entry: instruction word and the address it came from.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } dec_entry_t;

  // Clear the byte-offset bits so the address lands on an instruction boundary.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~(WORD_W'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; occupancy is exposed so callers can run credit schemes.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push while full is legal alongside it.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Next-state for storage, pointers and occupancy; flush discards everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // State registers; storage clears on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests and
// queues in-order responses for decode; redirects flush and drop stale data.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic              CLK,
  input  logic              Reset,
  output logic              imem_req_valid,
  output logic [WORD_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [WORD_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  output logic [WORD_W-1:0] dec_instr,
  output logic [WORD_W-1:0] dec_pc,
  input  logic              dec_ready,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] Out_PC
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = $bits(dec_entry_t);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              run_q, run_d;

  // The address FIFO occupancy is the outstanding-request count.
  logic [CW-1:0]     af_count;
  logic              af_empty, af_full;
  logic [WORD_W-1:0] af_head;

  logic [CW-1:0]     of_count;
  logic              of_empty, of_full;
  dec_entry_t        of_head, of_in;

  logic              req_fire, rsp_fire, dec_fire, of_push;
  logic [SW-1:0]     credit;

  // Credit covers both in-flight requests and queued instructions, so the
  // output FIFO can always absorb every response still owed.
  assign credit         = SW'(af_count) + SW'(of_count);
  assign imem_req_valid = run_q && (credit < SW'(DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && !af_empty;
  assign dec_fire = dec_valid && dec_ready;

  // Responses are dropped while stale ones are owed and in the redirect cycle.
  assign of_push = rsp_fire && (drop_cnt_q == '0) && !redirect_valid;
  assign of_in   = '{instr: imem_rsp_data, pc: af_head};

  assign dec_valid = !of_empty;
  assign dec_instr = of_head.instr;
  assign dec_pc    = of_head.pc;
  assign Out_PC    = pc_q;

  // PC advance, redirect target and stale-response bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    run_d      = 1'b1;
    if (redirect_valid) begin
      pc_d       = word_align(redirect_pc);
      drop_cnt_d = af_count + CW'(req_fire) - CW'(rsp_fire);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + WORD_W'(INSTR_BYTES);
      end
      if (rsp_fire && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  // Fetch control registers; run_q keeps requests quiet until reset is released.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
      run_q      <= run_d;
    end
  end

  // PCs of requests still owed by memory; never flushed.
  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk       (CLK),
    .rst_n     (Reset),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .pop_data  (af_head),
    .count     (af_count),
    .empty     (af_empty),
    .full      (af_full)
  );

  // Instruction/PC pairs waiting for decode.
  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk       (CLK),
    .rst_n     (Reset),
    .push      (of_push),
    .push_data (of_in),
    .pop       (dec_fire),
    .flush     (redirect_valid),
    .pop_data  (of_head),
    .count     (of_count),
    .empty     (of_empty),
    .full      (of_full)
  );

  // A response with nothing outstanding is a memory protocol error.
  a_rsp_owed: assert property (@(posedge CLK) disable iff (!Reset)
    imem_rsp_valid |-> !af_empty);

  // The credit rule keeps both FIFOs from overflowing.
  a_af_no_overflow: assert property (@(posedge CLK) disable iff (!Reset)
    !(req_fire && af_full && !rsp_fire));

  a_of_no_overflow: assert property (@(posedge CLK) disable iff (!Reset)
    !(of_push && of_full && !dec_fire));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;
  import mips_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] Out_PC;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .Out_PC         (Out_PC)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] pc; logic [31:0] instr; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ex_t;
  typedef struct { logic [31:0] data; int due; } mr_t;

  fl_t fl_q[$];          // requests accepted, answer still owed
  ex_t ex_q[$];          // instructions decode should see, in order
  mr_t mr_q[$];          // memory model pending responses
  logic [31:0] dec_log[$];
  logic [31:0] req_log[$];

  logic [31:0] m_pc = RESET_PC;
  bit          exp_rv = 1'b0;
  bit          in_reset = 1'b1;
  bit          started = 1'b0;
  int          edge_n = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          triple_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every decode handshake is compared against the scoreboard head.
  always @(negedge CLK) begin
    if (!in_reset) begin
      check("dec_valid", 32'(dec_valid), 32'(ex_q.size() != 0));
      if (dec_valid && dec_ready) begin
        if (ex_q.size() != 0) begin
          ex_t e;
          e = ex_q.pop_front();
          check("dec_pc", dec_pc, e.pc);
          check("dec_instr", dec_instr, e.instr);
        end
        dec_log.push_back(dec_pc);
      end
    end
  end

  // One clock: sample handshakes, check the request side, advance the model, drive memory.
  task automatic step();
    bit          s_req, s_rsp, s_redir;
    logic [31:0] s_addr, s_rpc;
    fl_t         f;
    int          due;
    @(negedge CLK);
    s_req   = imem_req_valid && imem_req_ready;
    s_addr  = imem_req_addr;
    s_rsp   = imem_rsp_valid;
    s_redir = redirect_valid;
    s_rpc   = redirect_pc;
    if (started) begin
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (imem_req_valid) check("req_addr", imem_req_addr, m_pc);
      check("out_pc", Out_PC, m_pc);
    end
    @(posedge CLK);
    #1;
    edge_n++;
    if (s_req && s_rsp && s_redir) triple_cnt++;
    if (s_rsp) begin
      mr_q.delete(0);
      f = fl_q.pop_front();
      if (!f.stale && !s_redir) ex_q.push_back('{f.pc, f.instr});
    end
    if (s_req) begin
      fl_q.push_back('{m_pc, memword(m_pc), 1'b0});
      due = edge_n + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mr_q.push_back('{memword(s_addr), due});
      req_log.push_back(s_addr);
      m_pc = m_pc + 32'd4;
    end
    if (s_redir) begin
      foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      ex_q.delete();
      m_pc = s_rpc & 32'hFFFF_FFFC;
    end
    started = 1'b1;
    exp_rv  = (fl_q.size() + ex_q.size()) < int'(DEPTH);
    if (mr_q.size() != 0 && mr_q[0].due == edge_n + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mr_q[0].data;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Assert reset (asynchronously, wherever we are), check reset values, release after an edge.
  task automatic apply_reset();
    Reset          = 1'b0;
    in_reset       = 1'b1;
    started        = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    fl_q.delete();
    ex_q.delete();
    mr_q.delete();
    #1;
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    check("rst_out_pc", Out_PC, RESET_PC);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_valid_hold", 32'(imem_req_valid), 32'd0);
    Reset    = 1'b1;
    in_reset = 1'b0;
    m_pc     = RESET_PC;
    last_due = edge_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] tgt [4] = '{32'hFFFF_FFF9, 32'h0000_2002, 32'h1234_5677, 32'h0000_0040};
  logic [31:0] exp_pc;
  int d0, r0, t0;
  bit ok;

  initial begin
    apply_reset();

    // Streaming with 1-cycle memory: one instruction per cycle once filled.
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; dec_ready = 1'b1;
    repeat (10) step();
    d0 = dec_log.size();
    repeat (30) step();
    check("p1_throughput", 32'(dec_log.size() - d0), 32'd30);
    check("p1_first_req", req_log[0], RESET_PC);

    // Decode stalled: exactly DEPTH requests, then drain in order.
    apply_reset();
    dec_ready = 1'b0;
    r0 = req_log.size();
    repeat (12) step();
    check("p2_req_count", 32'(req_log.size() - r0), 32'(DEPTH));
    check("p2_req_valid_low", 32'(imem_req_valid), 32'd0);
    dec_ready = 1'b1;
    d0 = dec_log.size();
    repeat (10) step();
    exp_pc = RESET_PC;
    for (int i = 0; i < 4; i++) begin
      check("p2_drain_pc", dec_log[d0 + i], exp_pc);
      exp_pc = exp_pc + 32'd4;
    end

    // 3-cycle memory, redirect to 0x103 with two requests in flight.
    apply_reset();
    lat_min = 3; lat_max = 3;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (fl_q.size() == 2) ok = 1'b1;
    end
    check("p3_two_inflight", 32'(ok), 32'd1);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    r0 = req_log.size(); d0 = dec_log.size();
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (req_log.size() != r0) ok = 1'b1;
    end
    check("p3_req_seen", 32'(ok), 32'd1);
    if (ok) check("p3_first_req_addr", req_log[r0], 32'h0000_0100);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      if (dec_log.size() != d0) ok = 1'b1;
    end
    check("p3_dec_seen", 32'(ok), 32'd1);
    if (ok) check("p3_first_dec_pc", dec_log[d0], 32'h0000_0100);

    // Redirect coinciding with a request accept and a response arrival.
    apply_reset();
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 4; k++) begin
      repeat (6) step();
      t0 = triple_cnt;
      redirect_valid = 1'b1; redirect_pc = tgt[k];
      step();
      redirect_valid = 1'b0;
      repeat (12) step();
      check("p4_triple_event", 32'(triple_cnt - t0), 32'd1);
      check("p4_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    end

    // Random backpressure, random latency, occasional redirects.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      imem_req_ready = 1'($urandom_range(1, 0));
      dec_ready      = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
    repeat (30) step();
    check("p5_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);

    // Reset in the middle of a stream with a full output queue.
    lat_min = 2; lat_max = 2;
    dec_ready = 1'b0;
    repeat (8) step();
    check("p6_queue_nonempty", 32'(dec_valid), 32'd1);
    #3;
    apply_reset();
    dec_ready = 1'b1; imem_req_ready = 1'b1;
    r0 = req_log.size();
    repeat (20) step();
    check("p6_restart_seen", 32'(req_log.size() > r0), 32'd1);
    if (req_log.size() > r0) check("p6_restart_pc", req_log[r0], RESET_PC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
